sr_deser: RTL and testbench

Parametrised serial-to-parallel deserializer for the on-chip shift-register family. It accepts 0..MAX_LANES serial bits per cycle and assembles them into WORD_W-bit words. It supports a per-channel reset phase offset, manual bit-slip and optional sync-word alignment (HUNT/LOCKED). Completed words pass to the downstream framer through a 2-entry ready/valid buffer, and a sticky overflow flag reports dropped words.

---
 rtl/sr_pkg.sv | 18 +
 rtl/sr_fifo2.sv | 55 +++++
 rtl/sr_deser.sv | 142 ++++++++++++++
 tb/tb_sr_deser.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and helpers for the sr_deser shift-register deserializer family.
//   sr_state_e      : alignment FSM states
//   sr_width()      : bit width needed to hold values 0..n-1 (never less than 1)
//   DefaultSyncWord : default alignment pattern
package sr_pkg;

  typedef enum logic [0:0] {
    HUNT,
    LOCKED
  } sr_state_e;

  localparam logic [15:0] DefaultSyncWord = 16'hF628;

  function automatic int unsigned sr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_fifo2.sv
// Two-entry first-word-fall-through ready/valid buffer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and word; ignored when full unless a pop
//                   happens in the same cycle
//   data_o        : head word (zero while empty)
//   valid_o       : head word valid
//   ready_i       : downstream accepts head
//   full_o        : both entries occupied
module sr_fifo2 #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             full_o
);

  logic [Width-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       count_q;
  logic             pop, push_ok;

  always_comb begin
    valid_o = (count_q != 2'd0);
    full_o  = (count_q == 2'd2);
    data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    pop     = valid_o & ready_i;
    // When full, a same-cycle pop frees the slot the push overwrites.
    push_ok = push_i & (~full_o | pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_ok) - 2'(pop);
    end
  end

endmodule

// File: rtl/sr_deser.sv
// Serial-to-parallel deserializer: 0..MAX_LANES bits per cycle assembled into
// WORD_W-bit words, with reset phase offset, bit-slip and sync-word alignment.
//   clk, rst_n  : clock, asynchronous active-low reset
//   datain      : serial bits, datain[nbits-1] oldest, datain[0] newest
//   nbits       : valid bit count this cycle (> MAX_LANES treated as 0)
//   align_en    : 1 = hunt for SYNC_WORD before framing, 0 = free-running framing
//   relock      : pulse, return to HUNT
//   bitslip     : pulse, drop the next incoming bit
//   ovf_clr     : pulse, clear ovf
//   dataout     : buffered word, oldest bit in MSB
//   out_valid   : dataout valid
//   out_ready   : downstream accepts
//   locked      : alignment FSM is LOCKED
//   ovf         : sticky, a completed word was dropped on a full buffer
module sr_deser
  import sr_pkg::*;
#(
  parameter int unsigned       WORD_W    = 16,
  parameter int unsigned       MAX_LANES = 2,
  parameter int unsigned       CHANNEL   = 0,
  parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(DefaultSyncWord)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [MAX_LANES-1:0]                datain,
  input  logic [sr_width(MAX_LANES+1)-1:0]    nbits,
  input  logic                                align_en,
  input  logic                                relock,
  input  logic                                bitslip,
  input  logic                                ovf_clr,
  output logic [WORD_W-1:0]                   dataout,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                locked,
  output logic                                ovf
);

  localparam int unsigned AccW = WORD_W + MAX_LANES - 1;
  localparam int unsigned NbW  = sr_width(MAX_LANES + 1);
  localparam int unsigned CntW = sr_width(WORD_W);
  localparam int unsigned SumW = sr_width(2 * WORD_W);
  localparam logic [CntW-1:0] CntRst = CntW'(CHANNEL % WORD_W);

  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              slip_q, slip_d;
  sr_state_e         state_q, state_d;
  logic              ovf_q, ovf_d;

  logic [NbW-1:0]    nb_eff, k;
  logic              slip_take;
  logic [AccW-1:0]   in_bits;
  logic [SumW-1:0]   sum, rem;
  logic              framing, push, match;
  logic [CntW-1:0]   match_pos;
  logic [WORD_W-1:0] push_word;
  logic              fifo_full;

  always_comb begin
    nb_eff    = (nbits <= NbW'(MAX_LANES)) ? nbits : '0;
    slip_take = slip_q && (nb_eff != '0);
    // A slip drops datain[nbits-1]; the accepted bits are always the low k bits.
    k         = nb_eff - NbW'(slip_take);
    slip_d    = slip_q ? ~slip_take : bitslip;

    in_bits = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (NbW'(i) < k) in_bits[i] = datain[i];
    end
    acc_d = (acc_q << k) | in_bits;

    sum       = SumW'(cnt_q) + SumW'(k);
    rem       = sum - SumW'(WORD_W);
    push_word = WORD_W'(acc_d >> rem);
    framing   = !align_en || (state_q == LOCKED);

    push      = 1'b0;
    match     = 1'b0;
    match_pos = '0;
    cnt_d     = cnt_q;
    state_d   = state_q;

    if (framing) begin
      if (sum >= SumW'(WORD_W)) begin
        push  = 1'b1;
        cnt_d = CntW'(rem);
      end else begin
        cnt_d = CntW'(sum);
      end
    end else begin
      // Ascending scan: the last hit is the highest index, i.e. the oldest bit.
      for (int unsigned j = 0; j < MAX_LANES; j++) begin
        if (NbW'(j) < k && acc_d[j +: WORD_W] == SYNC_WORD) begin
          match     = 1'b1;
          match_pos = CntW'(j);
        end
      end
    end

    if (relock) begin
      state_d = HUNT;
    end else if (match) begin
      state_d = LOCKED;
      cnt_d   = match_pos;
    end

    ovf_d = (ovf_q & ~ovf_clr) | (push & fifo_full & ~out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= CntRst;
      slip_q  <= 1'b0;
      state_q <= HUNT;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      slip_q  <= slip_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  sr_fifo2 #(
    .Width (WORD_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (push_word),
    .data_o  (dataout),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .full_o  (fifo_full)
  );

  assign locked = (state_q == LOCKED);
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_sr_deser.sv
// Bench for sr_deser: two instances (CHANNEL 0 and 1) share stimulus; a bit-level
// reference model per instance is compared on every falling edge.
module tb_sr_deser;
  localparam int unsigned W = 16;
  localparam int unsigned L = 2;
  localparam logic [15:0] SYNC = 16'hF628;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [L-1:0] datain = '0;
  logic [1:0]  nbits = '0;
  logic        align_en = 1'b0, relock = 1'b0, bitslip = 1'b0, ovf_clr = 1'b0;
  logic        out_ready = 1'b1;
  logic [W-1:0] dout [2];
  logic        vld [2];
  logic        lck [2];
  logic        ovf [2];

  sr_deser #(.WORD_W(W), .MAX_LANES(L), .CHANNEL(0), .SYNC_WORD(SYNC)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .datain(datain), .nbits(nbits), .align_en(align_en),
    .relock(relock), .bitslip(bitslip), .ovf_clr(ovf_clr), .dataout(dout[0]),
    .out_valid(vld[0]), .out_ready(out_ready), .locked(lck[0]), .ovf(ovf[0])
  );

  sr_deser #(.WORD_W(W), .MAX_LANES(L), .CHANNEL(1), .SYNC_WORD(SYNC)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .datain(datain), .nbits(nbits), .align_en(align_en),
    .relock(relock), .bitslip(bitslip), .ovf_clr(ovf_clr), .dataout(dout[1]),
    .out_valid(vld[1]), .out_ready(out_ready), .locked(lck[1]), .ovf(ovf[1])
  );

  always #5 clk = ~clk;

  // Reference model state
  int          mcnt [2];
  bit          mslip [2];
  bit          mlck [2];
  logic [15:0] mhist [2];
  logic [15:0] mbuf [2][2];
  int          mcount [2];
  bit          movf [2];
  logic [15:0] last_pop0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i]   = i % W;
      mslip[i]  = 1'b0;
      mlck[i]   = 1'b0;
      mhist[i]  = '0;
      mcount[i] = 0;
      movf[i]   = 1'b0;
    end
  endtask

  // One clock edge: bits are consumed oldest-first, one at a time.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int nb, k;
      bit take, frame, have, drop, pop, lock_now;
      logic [15:0] word;
      nb   = (int'(nbits) <= L) ? int'(nbits) : 0;
      take = mslip[i] && nb >= 1;
      k    = nb - (take ? 1 : 0);
      pop  = (mcount[i] > 0) && out_ready;
      if (mslip[i]) mslip[i] = !take;
      else mslip[i] = bitslip;
      frame = !align_en || mlck[i];
      have = 1'b0; lock_now = 1'b0; word = '0;
      for (int b = k - 1; b >= 0; b--) begin
        mhist[i] = {mhist[i][14:0], datain[b]};
        if (frame) begin
          mcnt[i]++;
          if (mcnt[i] == W) begin
            mcnt[i] = 0;
            have = 1'b1;
            word = mhist[i];
          end
        end else if (!relock && mhist[i] == SYNC) begin
          frame = 1'b1;
          mcnt[i] = 0;
          lock_now = 1'b1;
        end
      end
      if (relock) mlck[i] = 1'b0;
      else if (lock_now) mlck[i] = 1'b1;
      if (pop) begin
        mbuf[i][0] = mbuf[i][1];
        mcount[i]--;
      end
      drop = 1'b0;
      if (have) begin
        if (mcount[i] < 2) begin
          mbuf[i][mcount[i]] = word;
          mcount[i]++;
        end else begin
          drop = 1'b1;
        end
      end
      movf[i] = (movf[i] && !ovf_clr) || drop;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out_valid[%0d]", i), 32'(vld[i]), 32'(mcount[i] > 0));
      if (mcount[i] > 0) check($sformatf("dataout[%0d]", i), 32'(dout[i]), 32'(mbuf[i][0]));
      check($sformatf("locked[%0d]", i), 32'(lck[i]), 32'(mlck[i]));
      check($sformatf("ovf[%0d]", i), 32'(ovf[i]), 32'(movf[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (vld[0] && out_ready) last_pop0 = dout[0];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst out_valid", 32'(vld[i]), 32'd0);
      check("rst locked", 32'(lck[i]), 32'd0);
      check("rst ovf", 32'(ovf[i]), 32'd0);
      check("rst dataout", 32'(dout[i]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] v, input int nb, input bit clr_last,
                           input bit slip_first);
    for (int i = 0; i < 16 / nb; i++) begin
      nbits   = 2'(nb);
      datain  = (nb == 2) ? v[15 - 2 * i -: 2] : {1'b0, v[15 - i]};
      ovf_clr = clr_last && (i == 16 / nb - 1);
      bitslip = slip_first && (i == 0);
      step();
    end
    nbits = '0; ovf_clr = 1'b0; bitslip = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    logic [15:0] a5;
    #3;
    do_reset();

    // Free-running, one bit per cycle
    align_en = 1'b0; out_ready = 1'b1;
    a5 = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      nbits = 2'd1; datain = {1'b0, a5[15 - i]};
      step();
      if (i == 14) check("ch1 first word", 32'(dout[1]), 32'h52E1);
      if (i == 15) check("ch0 word", 32'({vld[0], dout[0]}), 32'h1A5C3);
    end
    nbits = '0;
    step();
    check("ch0 popped", 32'(vld[0]), 32'd0);

    // Two bits per cycle, odd remainder on channel 1
    do_reset();
    s = 32'hA5C3_1234;
    for (int i = 0; i < 16; i++) begin
      nbits = 2'd2; datain = s[31 - 2 * i -: 2];
      step();
      if (i == 7) check("nb2 ch1 w0", 32'(dout[1]), 32'h52E1);
      if (i == 7) check("nb2 ch0 w0", 32'(dout[0]), 32'hA5C3);
      if (i == 15) check("nb2 ch1 w1", 32'(dout[1]), 32'h891A);
      if (i == 15) check("nb2 ch0 w1", 32'(dout[0]), 32'h1234);
    end
    nbits = '0;
    step();

    // Sync-word alignment
    do_reset();
    align_en = 1'b1;
    send_word(16'h1234, 1, 1'b0, 1'b0);
    send_word(SYNC, 1, 1'b0, 1'b0);
    check("locked after sync", 32'(lck[0]), 32'd1);
    send_word(16'hBEEF, 1, 1'b0, 1'b0);
    check("first aligned word", 32'({vld[0], dout[0]}), 32'h1BEEF);
    check("first aligned word ch1", 32'({vld[1], dout[1]}), 32'h1BEEF);

    // Bit-slip on a locked 0x0F0F stream
    send_word(16'h0F0F, 2, 1'b0, 1'b0);
    send_word(16'h0F0F, 2, 1'b0, 1'b0);
    step();
    check("pre-slip word", 32'(last_pop0), 32'h0F0F);
    send_word(16'h0F0F, 2, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_word(16'h0F0F, 2, 1'b0, 1'b0);
    step();
    check("post-slip word", 32'(last_pop0), 32'h1E1E);

    // Backpressure and overflow
    do_reset();
    align_en = 1'b0; out_ready = 1'b0;
    send_word(16'hC0DE, 2, 1'b0, 1'b0);
    send_word(16'h5A5A, 2, 1'b0, 1'b0);
    send_word(16'h0FF0, 2, 1'b0, 1'b0);
    check("ovf after drop", 32'(ovf[0]), 32'd1);
    check("head intact", 32'(dout[0]), 32'hC0DE);
    send_word(16'h1357, 2, 1'b1, 1'b0);
    check("ovf set beats clr", 32'(ovf[0]), 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf cleared", 32'(ovf[0]), 32'd0);
    out_ready = 1'b1;
    step();
    check("second word intact", 32'(dout[0]), 32'h5A5A);
    step(); step();

    // Asynchronous reset mid-word with a buffered word
    do_reset();
    align_en = 1'b1; out_ready = 1'b1;
    send_word(SYNC, 2, 1'b0, 1'b0);
    out_ready = 1'b0;
    send_word(16'h7E81, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nbits = 2'd1; datain = 2'b01; step();
    end
    nbits = '0;
    check("pre-reset valid", 32'(vld[0]), 32'd1);
    #2;
    do_reset();
    align_en = 1'b0; out_ready = 1'b1;
    send_word(16'hA5C3, 1, 1'b0, 1'b0);
    check("restart ch0 word", 32'({vld[0], dout[0]}), 32'h1A5C3);

    // Randomized traffic
    for (int r = 0; r < 24; r++) begin
      align_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b1;
        send_word(SYNC, int'($urandom_range(1, 2)), 1'b0, 1'b0);
      end
      for (int c = 0; c < 40; c++) begin
        nbits     = 2'($urandom_range(0, 3));
        datain    = 2'($urandom);
        bitslip   = ($urandom_range(0, 15) == 0);
        relock    = ($urandom_range(0, 63) == 0);
        ovf_clr   = ($urandom_range(0, 31) == 0);
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      bitslip = 1'b0; relock = 1'b0; ovf_clr = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
